spi_master_param: RTL and testbench

//   Parametrised SPI master: successor to the fixed 8-bit SPI engine in tt_um_suba.

---
 rtl/spi_master_param_if.sv | 30 +++
 rtl/spi_master_param.sv | 169 ++++++++++++++++
 tb/tb_spi_master_param.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_param_if.sv
// Word-side handshake bundle for spi_master_param.
//   master modport: on-chip client (drives tx_data/tx_valid, observes the rest)
//   slave modport : the SPI engine (accepts words, returns received words)
// Signals:
//   tx_data  WIDTH  word to transmit, captured on accept
//   tx_valid 1      client requests a transfer
//   tx_ready 1      engine idle and able to accept
//   rx_data  WIDTH  last received word, held until the next completion
//   rx_valid 1      one-cycle pulse when rx_data updates
//   busy     1      transfer in progress (accept until tx_ready returns)
interface spi_master_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: WIDTH-bit words, sclk half-period of
// CLK_DIV clock_in cycles, any CPOL/CPHA mode, MSB- or LSB-first.
// Ports:
//   clock_in  system clock (posedge)
//   rs_n      asynchronous active-low reset
//   bus       word handshake (spi_master_param_if, slave modport)
//   sclk/mosi/cs_n  SPI pin outputs, miso SPI pin input
//   led       toggles on every completed transfer
//   loopback  present only with SPI_LOOPBACK_EN defined: samples internal
//             mosi instead of miso while pins keep being driven
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | tx_ready high, waiting for accept
// SETUP   | cs_n low, first bit presented (CPHA=0), CLK_DIV cycles
// SHIFT   | 2*WIDTH sclk edges, one every CLK_DIV cycles
// HOLD    | sclk back at idle level for CLK_DIV cycles, then completion
// GAP     | cs_n high for CLK_DIV cycles of minimum deselect time
module spi_master_param #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock_in,
  input  logic             rs_n,
  spi_master_param_if.slave bus,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n,
  output logic             led
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic             loopback
`endif
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_PENULT = EDGE_W'(2 * WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [WIDTH-1:0]  tx_sh, rx_sh;
  logic              started;
  logic              accept, div_tc, sclk_edge, edge_lead, last_edge;
  logic              sample_now, sample_bit;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    return MSB_FIRST ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
  endfunction

  // tx_ready stays low until the first clock after reset release
  assign bus.tx_ready = started & (state == ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);
  assign accept       = bus.tx_valid & bus.tx_ready;
  assign div_tc       = (div_cnt == DIV_LAST);
  // edge_cnt holds edges already made, so an even count means the next is leading
  assign edge_lead    = ~edge_cnt[0];
  assign last_edge    = (edge_cnt == EDGE_PENULT);
  assign sample_now   = sclk_edge & (edge_lead != CPHA);

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  always_ff @(posedge clock_in or negedge rs_n) begin
    if (!rs_n) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sclk_edge  = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SETUP;
      ST_SETUP: if (div_tc) begin
                  state_next = ST_SHIFT;
                  sclk_edge  = 1'b1;
                end
      ST_SHIFT: if (div_tc) begin
                  sclk_edge = 1'b1;
                  if (last_edge) state_next = ST_HOLD;
                end
      ST_HOLD:  if (div_tc) state_next = ST_GAP;
      ST_GAP:   if (div_tc) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Divider restarts at every state change and every sclk edge; edge counter
  // only clears while idle, so neither runs freely.
  always_ff @(posedge clock_in or negedge rs_n) begin
    if (!rs_n) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      if (state == ST_IDLE || state_next != state || div_tc) div_cnt <= '0;
      else                                                    div_cnt <= div_cnt + DIV_W'(1);
      if (state == ST_IDLE) edge_cnt <= '0;
      else if (sclk_edge)   edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge rs_n) begin
    if (!rs_n) begin
      sclk         <= CPOL;
      mosi         <= 1'b0;
      cs_n         <= 1'b1;
      tx_sh        <= '0;
      rx_sh        <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      led          <= 1'b0;
      started      <= 1'b0;
    end else begin
      started      <= 1'b1;
      bus.rx_valid <= 1'b0;
      if (accept) begin
        tx_sh <= bus.tx_data;
        rx_sh <= '0;
        cs_n  <= 1'b0;
        if (!CPHA) mosi <= head(bus.tx_data);
      end
      if (sclk_edge) begin
        sclk <= ~sclk;
        if (sample_now) begin
          rx_sh <= shift_in(rx_sh, sample_bit);
        end else if (CPHA) begin
          mosi  <= head(tx_sh);
          tx_sh <= shift_out(tx_sh);
        end else if (!last_edge) begin
          // CPHA=0: first bit was presented at accept, so advance before driving
          mosi  <= head(shift_out(tx_sh));
          tx_sh <= shift_out(tx_sh);
        end
      end
      if (state == ST_HOLD && div_tc) begin
        cs_n         <= 1'b1;
        bus.rx_data  <= rx_sh;
        bus.rx_valid <= 1'b1;
        led          <= ~led;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;
  localparam int WA = 8;
  localparam int DA = 2;
  localparam int WB = 16;
  localparam int DB = 3;
  localparam int LAT_A = 1 + (2 * WA + 1) * DA;
  localparam int LAT_B = 1 + (2 * WB + 1) * DB;

  logic clk  = 1'b0;
  logic rs_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_param_if #(.WIDTH(WA)) ifa ();
  spi_master_param_if #(.WIDTH(WB)) ifb ();

  logic scka, mosia, csa, leda;
  logic sckb, mosib, csb, ledb;
  logic misoa = 1'b0;
  logic misob = 1'b0;
`ifdef SPI_LOOPBACK_EN
  logic lb_a = 1'b0;
`endif

  // A: mode 0, MSB first.  B: mode 3, LSB first, wider word, odd divider.
  spi_master_param #(.WIDTH(WA), .CLK_DIV(DA), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clock_in(clk), .rs_n(rs_n), .bus(ifa), .sclk(scka), .mosi(mosia), .miso(misoa),
    .cs_n(csa), .led(leda)
`ifdef SPI_LOOPBACK_EN
    , .loopback(lb_a)
`endif
  );

  spi_master_param #(.WIDTH(WB), .CLK_DIV(DB), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clock_in(clk), .rs_n(rs_n), .bus(ifb), .sclk(sckb), .mosi(mosib), .miso(misob),
    .cs_n(csb), .led(ledb)
`ifdef SPI_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
    int          c0;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Behavioural SPI slaves: present a word, capture what the master sends
  logic [WA-1:0] slv_a, wa, capa, last_cap_a;
  logic [WB-1:0] slv_b, wb, capb, last_cap_b;
  int ia, lead_a, last_lead_a, edges_a;
  int ib, lead_b, last_lead_b;
  logic pcsa = 1'b1, pscka = 1'b0, pcsb = 1'b1, psckb = 1'b1;

  // mode 0, MSB first: data valid before rising edge, changes on falling edge
  always @(csa or scka) begin
    if (csa != pcsa) begin
      if (!csa) begin
        wa = slv_a; capa = '0; ia = 0; lead_a = 0; edges_a = 0;
        misoa = wa[WA-1];
      end else begin
        last_cap_a = capa; last_lead_a = lead_a;
      end
    end else if (!csa && scka != pscka) begin
      edges_a++;
      if (scka) begin
        if (ia < WA) capa[WA-1-ia] = mosia;
        lead_a++;
      end else begin
        ia++;
        if (ia < WA) misoa = wa[WA-1-ia];
      end
    end
    pcsa = csa; pscka = scka;
  end

  // mode 3, LSB first: slave drives on falling (leading) edge, samples on rising
  always @(csb or sckb) begin
    if (csb != pcsb) begin
      if (!csb) begin
        wb = slv_b; capb = '0; ib = 0; lead_b = 0; misob = 1'b0;
      end else begin
        last_cap_b = capb; last_lead_b = lead_b;
      end
    end else if (!csb && sckb != psckb) begin
      if (!sckb) begin
        if (ib < WB) misob = wb[ib];
        lead_b++;
      end else begin
        if (ib < WB) capb[ib] = mosib;
        ib++;
      end
    end
    pcsb = csb; psckb = sckb;
  end

  // Monitor: pops the scoreboard whenever a DUT reports a received word
  logic led_exp_a, led_exp_b, prv_a, prv_b;
  int hi_a, gap_a;
  always @(negedge clk) begin
    if (!rs_n) begin
      led_exp_a = 1'b0; led_exp_b = 1'b0; hi_a = 0; prv_a = 1'b0; prv_b = 1'b0;
    end else begin
      if (csa) hi_a++;
      else begin
        if (hi_a != 0) gap_a = hi_a;
        hi_a = 0;
      end
      if (ifa.rx_valid) begin
        if (qa.size() == 0) fail_now("a_spurious_rx_valid");
        else begin
          ea = qa.pop_front();
          chk("a_rx_data", 32'(ifa.rx_data), ea.rx);
          chk("a_latency", cyc - ea.c0, LAT_A);
          chk("a_slave_saw_mosi", 32'(last_cap_a), ea.tx);
          chk("a_sclk_pulses", last_lead_a, WA);
          led_exp_a = ~led_exp_a;
          chk("a_led", leda, led_exp_a);
          chk("a_rx_valid_single", prv_a, 0);
        end
      end
      if (ifb.rx_valid) begin
        if (qb.size() == 0) fail_now("b_spurious_rx_valid");
        else begin
          eb = qb.pop_front();
          chk("b_rx_data", 32'(ifb.rx_data), eb.rx);
          chk("b_latency", cyc - eb.c0, LAT_B);
          chk("b_slave_saw_mosi", 32'(last_cap_b), eb.tx);
          chk("b_sclk_pulses", last_lead_b, WB);
          chk("b_sclk_idle_high", sckb, 1);
          led_exp_b = ~led_exp_b;
          chk("b_led", ledb, led_exp_b);
          chk("b_rx_valid_single", prv_b, 0);
        end
      end
      prv_a = ifa.rx_valid;
      prv_b = ifb.rx_valid;
    end
  end

  task automatic send_a(input logic [WA-1:0] d, input logic [WA-1:0] sw,
                        input logic [WA-1:0] exp, input bit keep);
    int n = 0;
    slv_a = sw; ifa.tx_data = d; ifa.tx_valid = 1'b1;
    while (!ifa.tx_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      fail_now("a_accept_timeout");
      ifa.tx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    qa.push_back('{tx: 32'(d), rx: 32'(exp), c0: cyc - 1});
    if (!keep) begin ifa.tx_valid = 1'b0; ifa.tx_data = WA'($urandom); end
  endtask

  task automatic send_b(input logic [WB-1:0] d, input logic [WB-1:0] sw, input logic [WB-1:0] exp);
    int n = 0;
    slv_b = sw; ifb.tx_data = d; ifb.tx_valid = 1'b1;
    while (!ifb.tx_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      fail_now("b_accept_timeout");
      ifb.tx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    qb.push_back('{tx: 32'(d), rx: 32'(exp), c0: cyc - 1});
    ifb.tx_valid = 1'b0; ifb.tx_data = WB'($urandom);
  endtask

  // Wait for completion; optionally poke tx_valid with junk while busy
  task automatic idle_a(input bit pulses);
    int n = 0;
    do begin
      @(negedge clk);
      if (pulses && ifa.busy && $urandom_range(3) == 0) begin
        ifa.tx_valid = 1'b1; ifa.tx_data = WA'($urandom);
      end else ifa.tx_valid = 1'b0;
      n++;
    end while ((ifa.busy || qa.size() != 0) && n < 2000);
    if (n >= 2000) fail_now("a_completion_timeout");
  endtask

  task automatic idle_b(input bit pulses);
    int n = 0;
    do begin
      @(negedge clk);
      if (pulses && ifb.busy && $urandom_range(3) == 0) begin
        ifb.tx_valid = 1'b1; ifb.tx_data = WB'($urandom);
      end else ifb.tx_valid = 1'b0;
      n++;
    end while ((ifb.busy || qb.size() != 0) && n < 2000);
    if (n >= 2000) fail_now("b_completion_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    ifa.tx_valid = 1'b0; ifa.tx_data = '0; slv_a = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0; slv_b = '0;
    rs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_a_cs_n", csa, 1);
    chk("rst_a_sclk", scka, 0);
    chk("rst_a_mosi", mosia, 0);
    chk("rst_a_tx_ready", ifa.tx_ready, 0);
    chk("rst_a_busy", ifa.busy, 0);
    chk("rst_a_rx_data", 32'(ifa.rx_data), 0);
    chk("rst_a_rx_valid", ifa.rx_valid, 0);
    chk("rst_a_led", leda, 0);
    chk("rst_b_sclk", sckb, 1);
    chk("rst_b_cs_n", csb, 1);
    rs_n = 1'b1;
    @(negedge clk);
    chk("a_ready_after_reset", ifa.tx_ready, 1);
    chk("b_ready_after_reset", ifb.tx_ready, 1);

    send_a(8'hA5, 8'h3C, 8'h3C, 1'b0);
    idle_a(1'b0);
    send_b(16'h8001, 16'h1234, 16'h1234);
    idle_b(1'b0);
    send_b(16'h005A, 16'hBEEF, 16'hBEEF);
    idle_b(1'b1);

    // back-to-back with tx_valid held high
    send_a(8'h11, 8'h7E, 8'h7E, 1'b1);
    send_a(8'h22, 8'h81, 8'h81, 1'b0);
    idle_a(1'b1);
    chk("a_b2b_cs_n_high_cycles", gap_a, DA + 1);

    fork
      for (int i = 0; i < 12; i++) begin
        logic [WA-1:0] d, w;
        d = WA'($urandom); w = WA'($urandom);
        repeat ($urandom_range(3)) @(negedge clk);
        send_a(d, w, w, 1'b0);
        idle_a(1'b1);
      end
      for (int j = 0; j < 5; j++) begin
        logic [WB-1:0] d, w;
        d = WB'($urandom); w = WB'($urandom);
        repeat ($urandom_range(3)) @(negedge clk);
        send_b(d, w, w);
        idle_b(1'b1);
      end
    join

    // reset in the middle of a transfer, with the led already at 0
    if (led_exp_a) begin
      send_a(8'h0F, 8'hF0, 8'hF0, 1'b0);
      idle_a(1'b0);
    end
    send_a(8'h96, 8'h69, 8'h69, 1'b0);
    n = 0;
    while (edges_a < 6 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail_now("a_edge6_timeout");
    rs_n = 1'b0;
    #1;
    chk("midrst_cs_n", csa, 1);
    chk("midrst_sclk", scka, 0);
    chk("midrst_busy", ifa.busy, 0);
    chk("midrst_led", leda, 0);
    qa.delete();
    repeat (3) @(negedge clk);
    rs_n = 1'b1;
    @(negedge clk);
    send_a(8'h5C, 8'hE1, 8'hE1, 1'b0);
    idle_a(1'b0);

`ifdef SPI_LOOPBACK_EN
    lb_a = 1'b1;
    send_a(8'hC3, 8'h00, 8'hC3, 1'b0);
    idle_a(1'b0);
    lb_a = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
